miner_nonce_scheduler: RTL and testbench

Work scheduler sitting between the OCL register file and a bank of `CORES` miner cores. On each new-block trigger it latches the 640-bit header, restarts every core with a disjoint slice of the 32-bit nonce space, and collects found nonces. Collection uses per-core edge capture, a round-robin arbiter and a small result FIFO that software drains through a valid/ready pop interface.

---
 rtl/miner_sched_pkg.sv | 24 ++
 rtl/sched_result_fifo.sv | 58 +++++
 rtl/miner_nonce_scheduler.sv | 164 ++++++++++++++++
 tb/tb_miner_nonce_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_sched_pkg.sv
// Shared types, widths and the nonce-slicing helper for the nonce scheduler.
package miner_sched_pkg;

    localparam int BLOCK_W = 640;
    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

    // Start of core i's slice: the top log2(cores) bits of the nonce are the core index.
    function automatic logic [NONCE_W-1:0] slice_start(input int unsigned i, input int unsigned cores);
        int unsigned lg;
        lg = 0;
        for (int k = 0; k < 5; k++) begin
            if ((32'd1 << k) < cores) lg = k + 1;
        end
        if (lg == 0) return '0;
        return NONCE_W'(i) << (NONCE_W - lg);
    endfunction

endpackage

// File: rtl/sched_result_fifo.sv
// First-word-fall-through result FIFO: the head is visible whenever empty is low.
// A push is accepted on a full FIFO when a pop happens in the same cycle.
// flush empties the FIFO and overrides push and pop.
module sched_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW + 1)'(DEPTH));
    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && !flush && (!full || w_do_pop);
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/miner_nonce_scheduler.sv
// Nonce scheduler: restarts all cores on a new block with disjoint nonce
// slices, captures found-nonce edges and queues them round-robin into a FIFO.
// Handshake: a result leaves the FIFO in a cycle where result_valid and
// result_ready are both high; result_nonce holds while valid is high and ready low.
module miner_nonce_scheduler
    import miner_sched_pkg::*;
#(
    parameter int CORES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_block,
    input  logic [BLOCK_W-1:0]       inblock,
    output logic [CORES-1:0]         core_reset,
    output logic [BLOCK_W-1:0]       core_block,
    output logic [CORES*NONCE_W-1:0] core_nonce_start,
    input  logic [CORES-1:0]         core_found,
    input  logic [CORES*NONCE_W-1:0] core_nonce,
    output logic                     result_valid,
    output logic [NONCE_W-1:0]       result_nonce,
    input  logic                     result_ready,
    output logic                     busy,
    output logic                     solved,
    output logic                     overflow,
    output logic [31:0]              run_cycles,
    output sched_state_t             dbg_state
);

    localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    sched_state_t       r_state;
    sched_state_t       w_state_next;
    logic [BLOCK_W-1:0] r_block;
    logic [CORES-1:0]   r_found_q;
    logic [CORES-1:0]   r_pend;
    logic [CORES-1:0]   w_event;
    logic [CORES-1:0]   w_grant_oh;
    logic [NONCE_W-1:0] r_nonce [CORES];
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_cand;
    logic               w_grant_valid;
    logic               w_arb_en;
    logic               w_run;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               r_solved;
    logic               r_overflow;
    logic [31:0]        r_run_cycles;

    // A new_block flush takes priority over capture, arbitration and pop.
    assign w_run    = (r_state == RUN) && !new_block;
    assign w_pop    = result_ready && !w_empty;
    assign w_arb_en = w_run && (!w_full || w_pop);
    assign w_event  = w_run ? (core_found & ~r_found_q) : '0;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state; the core restart pulse is the one ARM cycle.
    always_comb begin
        w_state_next = r_state;
        core_reset   = '0;
        case (r_state)
            IDLE: w_state_next = IDLE;
            ARM: begin
                w_state_next = RUN;
                core_reset   = '1;
            end
            RUN:     w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
        if (new_block) w_state_next = ARM;
    end

    // Round-robin grant: first pending core at or after the pointer, wrapping.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_grant_oh    = '0;
        w_cand        = '0;
        for (int k = 0; k < CORES; k++) begin
            w_cand = r_rr_ptr + PTR_W'(k);
            if (w_arb_en && !w_grant_valid && r_pend[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
        if (w_grant_valid) w_grant_oh[w_grant_idx] = 1'b1;
    end

    // Edge capture, pending bits, per-core nonce latches and the RR pointer.
    // The edge register tracks core_found every cycle, so levels already high
    // during ARM are not seen as events in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_found_q  <= '0;
            r_pend     <= '0;
            r_overflow <= 1'b0;
            r_rr_ptr   <= '0;
            for (int i = 0; i < CORES; i++) r_nonce[i] <= '0;
        end else begin
            r_found_q <= core_found;
            if (new_block) r_pend <= '0;
            else           r_pend <= (r_pend & ~w_grant_oh) | w_event;
            if (|(w_event & r_pend & ~w_grant_oh)) r_overflow <= 1'b1;
            for (int i = 0; i < CORES; i++) begin
                if (w_event[i]) r_nonce[i] <= core_nonce[i*NONCE_W +: NONCE_W];
            end
            if (w_grant_valid) r_rr_ptr <= (CORES == 1) ? '0 : w_grant_idx + PTR_ONE;
        end
    end

    // Header latch, solved flag and RUN cycle counter, all restarted by new_block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_block      <= '0;
            r_solved     <= 1'b0;
            r_run_cycles <= '0;
        end else if (new_block) begin
            r_block      <= inblock;
            r_solved     <= 1'b0;
            r_run_cycles <= '0;
        end else begin
            if (w_grant_valid) r_solved <= 1'b1;
            if ((r_state == RUN) && (r_run_cycles != 32'hFFFF_FFFF))
                r_run_cycles <= r_run_cycles + 32'd1;
        end
    end

    sched_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NONCE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (new_block),
        .push      (w_grant_valid),
        .push_data (r_nonce[w_grant_idx]),
        .pop       (result_ready),
        .pop_data  (result_nonce),
        .full      (w_full),
        .empty     (w_empty)
    );

    for (genvar gi = 0; gi < CORES; gi++) begin : g_start
        assign core_nonce_start[gi*NONCE_W +: NONCE_W] = slice_start(gi, CORES);
    end

    assign result_valid = !w_empty;
    assign core_block   = r_block;
    assign busy         = (r_state != IDLE);
    assign solved       = r_solved;
    assign overflow     = r_overflow;
    assign run_cycles   = r_run_cycles;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// Directed bench for miner_nonce_scheduler (CORES=4, FIFO_DEPTH=4).
// Inputs change #1 after a rising edge; outputs are checked at that same point.
module tb_miner_nonce_scheduler;
    import miner_sched_pkg::*;

    logic           clk;
    logic           reset;
    logic           new_block;
    logic [639:0]   inblock;
    logic [3:0]     core_reset;
    logic [639:0]   core_block;
    logic [127:0]   core_nonce_start;
    logic [3:0]     core_found;
    logic [127:0]   core_nonce;
    logic           result_valid;
    logic [31:0]    result_nonce;
    logic           result_ready;
    logic           busy;
    logic           solved;
    logic           overflow;
    logic [31:0]    run_cycles;
    sched_state_t   dbg_state;

    int checks;
    int errors;

    logic [639:0] blk_a5;
    logic [639:0] blk_5a;

    miner_nonce_scheduler #(.CORES(4), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .new_block        (new_block),
        .inblock          (inblock),
        .core_reset       (core_reset),
        .core_block       (core_block),
        .core_nonce_start (core_nonce_start),
        .core_found       (core_found),
        .core_nonce       (core_nonce),
        .result_valid     (result_valid),
        .result_nonce     (result_nonce),
        .result_ready     (result_ready),
        .busy             (busy),
        .solved           (solved),
        .overflow         (overflow),
        .run_cycles       (run_cycles),
        .dbg_state        (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_nonce(input int i, input logic [31:0] v);
        core_nonce[i*32 +: 32] = v;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_core_reset"}, 640'(core_reset), 640'(4'h0));
        chk({tag, "_core_block"}, core_block, '0);
        chk({tag, "_starts"}, 640'(core_nonce_start),
            640'({32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}));
        chk({tag, "_valid"}, 640'(result_valid), 640'(1'b0));
        chk({tag, "_nonce"}, 640'(result_nonce), 640'(32'h0));
        chk({tag, "_busy"}, 640'(busy), 640'(1'b0));
        chk({tag, "_solved"}, 640'(solved), 640'(1'b0));
        chk({tag, "_overflow"}, 640'(overflow), 640'(1'b0));
        chk({tag, "_run_cycles"}, 640'(run_cycles), 640'(32'h0));
        chk({tag, "_state"}, 640'(dbg_state), 640'(IDLE));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        blk_a5       = {20{32'hA5A5_A5A5}};
        blk_5a       = {20{32'h5A5A_5A5A}};
        reset        = 1'b1;
        new_block    = 1'b0;
        inblock      = '0;
        core_found   = '0;
        core_nonce   = '0;
        result_ready = 1'b0;

        // Reset values.
        tick();
        tick();
        chk_reset_values("rst");
        reset = 1'b0;
        tick();

        // New block A5..A5: ARM at t+1, RUN at t+2, first count at t+3.
        inblock   = blk_a5;
        new_block = 1'b1;
        tick();
        new_block = 1'b0;
        inblock   = '0;
        chk("arm_core_reset", 640'(core_reset), 640'(4'hF));
        chk("arm_core_block", core_block, blk_a5);
        chk("arm_state", 640'(dbg_state), 640'(ARM));
        chk("arm_busy", 640'(busy), 640'(1'b1));
        chk("arm_run_cycles", 640'(run_cycles), 640'(32'd0));
        tick();
        chk("run_core_reset", 640'(core_reset), 640'(4'h0));
        chk("run_state", 640'(dbg_state), 640'(RUN));
        chk("run_core_block_held", core_block, blk_a5);
        chk("run_cycles_t2", 640'(run_cycles), 640'(32'd0));
        tick();
        chk("run_cycles_t3", 640'(run_cycles), 640'(32'd1));

        // Core 2 finds 0x80001234 with result_ready low.
        core_found[2] = 1'b1;
        set_nonce(2, 32'h8000_1234);
        tick();
        chk("evt_valid_t1", 640'(result_valid), 640'(1'b0));
        set_nonce(2, 32'hDEAD_BEEF);
        tick();
        chk("evt_valid_t2", 640'(result_valid), 640'(1'b1));
        chk("evt_nonce_t2", 640'(result_nonce), 640'(32'h8000_1234));
        chk("evt_solved", 640'(solved), 640'(1'b1));
        tick();
        chk("evt_valid_hold", 640'(result_valid), 640'(1'b1));
        chk("evt_nonce_hold", 640'(result_nonce), 640'(32'h8000_1234));
        result_ready = 1'b1;
        tick();
        result_ready  = 1'b0;
        core_found[2] = 1'b0;
        chk("evt_popped", 640'(result_valid), 640'(1'b0));

        // Core 0 alone: moves the round-robin pointer to 1.
        core_found[0] = 1'b1;
        set_nonce(0, 32'h0000_0A00);
        tick();
        core_found[0] = 1'b0;
        tick();
        chk("c0_nonce", 640'(result_nonce), 640'(32'h0000_0A00));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("c0_popped", 640'(result_valid), 640'(1'b0));

        // All four cores at once; pushes go 1, 2, 3, 0 and fill the FIFO.
        core_found = 4'hF;
        set_nonce(0, 32'h0000_0010);
        set_nonce(1, 32'h4000_0011);
        set_nonce(2, 32'h8000_0022);
        set_nonce(3, 32'hC000_0033);
        tick();
        core_found = 4'h0;
        chk("rr_empty_a1", 640'(result_valid), 640'(1'b0));
        tick();
        chk("rr_head_a2", 640'(result_nonce), 640'(32'h4000_0011));
        tick();
        tick();
        tick();

        // FIFO full: core 0 rises twice without being granted.
        core_found[0] = 1'b1;
        set_nonce(0, 32'h0000_AAAA);
        tick();
        core_found[0] = 1'b0;
        chk("full_no_ovf_yet", 640'(overflow), 640'(1'b0));
        tick();
        core_found[0] = 1'b1;
        set_nonce(0, 32'h0000_BBBB);
        tick();
        core_found[0] = 1'b0;
        chk("ovf_set", 640'(overflow), 640'(1'b1));
        chk("full_head_stable", 640'(result_nonce), 640'(32'h4000_0011));

        // Drain five entries: round-robin order, then core 0's newer nonce.
        result_ready = 1'b1;
        chk("drain0", 640'(result_nonce), 640'(32'h4000_0011));
        tick();
        chk("drain1", 640'(result_nonce), 640'(32'h8000_0022));
        tick();
        chk("drain2", 640'(result_nonce), 640'(32'hC000_0033));
        tick();
        chk("drain3", 640'(result_nonce), 640'(32'h0000_0010));
        tick();
        chk("drain4", 640'(result_nonce), 640'(32'h0000_BBBB));
        chk("drain4_valid", 640'(result_valid), 640'(1'b1));
        tick();
        result_ready = 1'b0;
        chk("drain_empty", 640'(result_valid), 640'(1'b0));

        // Queue one result, then new_block together with a pop and an event.
        core_found[3] = 1'b1;
        set_nonce(3, 32'hC000_7777);
        tick();
        tick();
        chk("pre_flush_nonce", 640'(result_nonce), 640'(32'hC000_7777));
        result_ready  = 1'b1;
        new_block     = 1'b1;
        inblock       = blk_5a;
        core_found[1] = 1'b1;
        set_nonce(1, 32'h4000_9999);
        tick();
        result_ready = 1'b0;
        new_block    = 1'b0;
        chk("flush_valid", 640'(result_valid), 640'(1'b0));
        chk("flush_solved", 640'(solved), 640'(1'b0));
        chk("flush_run_cycles", 640'(run_cycles), 640'(32'd0));
        chk("flush_core_reset", 640'(core_reset), 640'(4'hF));
        chk("flush_core_block", core_block, blk_5a);
        chk("flush_ovf_kept", 640'(overflow), 640'(1'b1));
        tick();
        tick();
        tick();
        chk("flush_no_result", 640'(result_valid), 640'(1'b0));
        chk("flush_no_solved", 640'(solved), 640'(1'b0));
        chk("flush_run_cycles_2", 640'(run_cycles), 640'(32'd2));

        // Reset in RUN with entries queued.
        core_found = 4'h0;
        tick();
        core_found = 4'b0101;
        set_nonce(0, 32'h0000_5555);
        set_nonce(2, 32'h8000_5555);
        tick();
        tick();
        tick();
        chk("pre_reset_valid", 640'(result_valid), 640'(1'b1));
        reset = 1'b1;
        tick();
        chk_reset_values("midrun");
        core_found = 4'h0;
        tick();
        chk("midrun_core_reset_2", 640'(core_reset), 640'(4'h0));
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
